unique_serializer: RTL and testbench
====================================

# unique_serializer

- Downstream neighbour of the 9-input duplicate-removal stage.
- Captures one frame (nine 8-bit slots plus `unique_count`) through a valid/ready handshake, then streams only the first `unique_count` slots out one byte per beat.
- Output stream uses valid/ready with a last-beat marker, so later byte-wide consumers (checkers, UART/AXI-Stream bridges) never see the zero padding.

## Interface
Parameters:
- `DATA_W`, 8, width of each slot and of `out_data`
- `SLOTS`, 9, number of input slots; fixed at 9 in this design, `unique_count` is 4 bits

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  frame on `in1..in9`/`unique_count` is valid
- `in_ready`  out  1  block can capture a frame this cycle
- `in1`..`in9`  in  DATA_W each  deduplicated slots, compacted from `in1` upward
- `unique_count`  in  4  number of meaningful slots, 0..9
- `out_valid`  out  1  `out_data` holds a valid beat
- `out_ready`  in  1  consumer accepts beat
- `out_data`  out  DATA_W  current unique value
- `out_index`  out  4  1-based slot index of the current beat
- `out_last`  out  1  current beat is the final one of its frame
- `frames_done`  out  8  count of fully emitted frames, wraps 255→0
- `empty_frames`  out  8  count of captured frames with count 0, wraps 255→0

## Operation
- States: IDLE, SEND.
- **IDLE**
  - `in_ready` = 1 (forced 0 while `rst` high).
  - On `in_valid && in_ready`, register all nine slots into `buf[1..9]` and latch `len = min(unique_count, 9)`.
  - `unique_count` values 10..15 clamp to 9.
  - `len == 0`: stay in IDLE, increment `empty_frames`, emit no beats.
  - `len >= 1`: go to SEND, with `idx` = 1, `out_data` = `buf[1]`, `out_index` = 1, `out_valid` = 1, `out_last` = (`len == 1`).
- **SEND**
  - `in_ready` = 0.
  - On `out_valid && out_ready` with `idx < len`: `idx` ← `idx + 1`, load `buf[idx+1]` into `out_data`, update `out_index` and `out_last`.
  - On `out_valid && out_ready` with `idx == len`: `out_valid` ← 0, `out_last` ← 0, increment `frames_done`, return to IDLE.
  - Without `out_ready`: `out_data`, `out_index`, `out_last` and `out_valid` are held unchanged (AXI-Stream stability rule).
- Slots beyond `len` are never emitted, even if nonzero.
- Input slot contents are not re-checked for duplicates; the upstream stage guarantees uniqueness.
- Input data is sampled only on the capture edge. Changes on `in*` during SEND are ignored.
- Width rules:
  - `idx`/`len` are 4-bit, compared unsigned.
  - Counters are 8-bit modulo.

## Timing
- Reset: synchronous. The cycle after `rst` is sampled high:
  - state = IDLE
  - `out_valid` = 0, `out_last` = 0
  - `out_data` = 0, `out_index` = 0
  - `frames_done` = 0, `empty_frames` = 0
  - `buf` cleared to 0
- Reset wins over every other event in the same cycle.
- Reset asserted mid-frame discards the remaining beats. No partial `frames_done` increment.
- Capture latency: `out_valid` rises on the edge that captures the frame (first beat visible the cycle after handshake).
- Per-frame occupancy with `out_ready` held high: `len` cycles in SEND.
- `in_ready` returns the cycle after the last beat is accepted. Back-to-back frames therefore cost `len + 1` cycles each.
- An empty frame costs 1 cycle; `in_ready` stays high.
- `in_valid` high while `in_ready` = 0 is not consumed. The upstream holds the frame, and the block does not capture it later on its own.
- Simultaneous last-beat acceptance and `in_valid`: the frame is not captured that cycle. It is captured the next cycle in IDLE.

## Test plan
- **Reset state:** assert `rst` 2 cycles → `out_valid`=0, `in_ready`=0 during reset and 1 after, both counters 0.
- **Single frame:** slots 5,3,9,0…0 with count 3, `out_ready`=1 → beats 5/idx1, 3/idx2, 9/idx3 on consecutive cycles, `out_last` only on 9, `frames_done`=1, `in_ready` high one cycle later.
- **Backpressure:** count 9, slots 1..9, `out_ready` toggling 1,0,0,1… → each value held stable while stalled, exactly 9 beats in order 1..9, no duplicate or skipped beat.
- **Empty and clamp:** count 0 → no beats, `empty_frames`=1. Count 15 with slots 10..18 → 9 beats 10..18, `out_last` on 18.
- **Reset mid-frame:** count 6, assert `rst` after beat 2 accepted → `out_valid`=0 next cycle, `frames_done` unchanged (0). The next frame, count 1 value 0xAA, emits a single `out_last` beat 0xAA.
- **Back-to-back and wrap:** 256 frames of count 1 with `in_valid` held high → each frame takes 2 cycles, `frames_done` wraps to 0, and `in_ready` is never high in SEND.

Source files
------------

// File: rtl/unique_serializer.sv
// unique_serializer: captures one deduplicated frame (nine slots plus a count)
// and streams the first unique_count slots out one byte per beat, flagging the
// final beat with out_last so downstream consumers never see the zero padding.
module unique_serializer #(
   parameter int DATA_W = 8,
   parameter int SLOTS  = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic [DATA_W-1:0] in4,
   input  logic [DATA_W-1:0] in5,
   input  logic [DATA_W-1:0] in6,
   input  logic [DATA_W-1:0] in7,
   input  logic [DATA_W-1:0] in8,
   input  logic [DATA_W-1:0] in9,
   input  logic [3:0]        unique_count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        out_index,
   output logic              out_last,
   output logic [7:0]        frames_done,
   output logic [7:0]        empty_frames
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                        state_q, state_d;
   logic [SLOTS-1:0][DATA_W-1:0]  buf_q, buf_d;
   logic [3:0]                    len_q, len_d;
   logic [3:0]                    idx_q, idx_d;
   logic [DATA_W-1:0]             data_q, data_d;
   logic                          valid_q, valid_d;
   logic                          last_q, last_d;
   logic [7:0]                    fdone_q, fdone_d;
   logic [7:0]                    empty_q, empty_d;

   // slot 0 of the packed frame is in1, so buffer index = 1-based slot - 1
   logic [SLOTS-1:0][DATA_W-1:0]  slots_in;
   logic [3:0]                    cnt_clamp;

   assign slots_in  = {in9, in8, in7, in6, in5, in4, in3, in2, in1};
   assign cnt_clamp = (unique_count > 4'(SLOTS)) ? 4'(SLOTS) : unique_count;

   // ready only while idle; held low during reset so no frame sneaks in
   assign in_ready     = (state_q == IDLE) && !rst;
   assign out_valid    = valid_q;
   assign out_data     = data_q;
   assign out_index    = idx_q;
   assign out_last     = last_q;
   assign frames_done  = fdone_q;
   assign empty_frames = empty_q;

   // next-state: capture in IDLE, advance/finish on each accepted beat in SEND
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      len_d   = len_q;
      idx_d   = idx_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      fdone_d = fdone_q;
      empty_d = empty_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               buf_d = slots_in;
               len_d = cnt_clamp;
               if (cnt_clamp == 4'd0) begin
                  empty_d = empty_q + 8'd1;
               end else begin
                  // first beat comes straight from the input so it is visible
                  // the cycle after the handshake
                  state_d = SEND;
                  idx_d   = 4'd1;
                  data_d  = in1;
                  valid_d = 1'b1;
                  last_d  = (cnt_clamp == 4'd1);
               end
            end
         end
         SEND: begin
            if (valid_q && out_ready) begin
               if (idx_q < len_q) begin
                  // buf_q[idx_q] is 1-based slot idx_q+1
                  idx_d  = idx_q + 4'd1;
                  data_d = buf_q[idx_q];
                  last_d = ((idx_q + 4'd1) == len_q);
               end else begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  fdone_d = fdone_q + 8'd1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state register; synchronous reset discards any frame in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         buf_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         fdone_q <= '0;
         empty_q <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         fdone_q <= fdone_d;
         empty_q <= empty_d;
      end
   end

endmodule

// File: tb/tb_unique_serializer.sv
// Scoreboard bench for unique_serializer: stimulus pushes hand-computed beats
// into a queue, a negedge monitor pops and compares every accepted beat.
module tb_unique_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0, in5 = '0;
   logic [7:0] in6 = '0, in7 = '0, in8 = '0, in9 = '0;
   logic [3:0] unique_count = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic [3:0] out_index;
   logic       out_last;
   logic [7:0] frames_done;
   logic [7:0] empty_frames;

   unique_serializer #(.DATA_W(8), .SLOTS(9)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
      .in6(in6), .in7(in7), .in8(in8), .in9(in9),
      .unique_count(unique_count), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_index(out_index), .out_last(out_last),
      .frames_done(frames_done), .empty_frames(empty_frames)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] index;
      logic       last;
   } beat_t;

   beat_t q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    cyc   = 0;
   int    viol  = 0;
   int    ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0
   int    last_cap = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // out_ready driver
   initial begin
      int ph = 0;
      forever begin
         @(posedge clk); #1;
         if (ready_mode == 0) out_ready = 1'b1;
         else begin
            out_ready = (ph == 0);
            ph = (ph + 1) % 3;
         end
      end
   end

   // monitor: compares every beat that will be accepted on the next edge,
   // and checks a stalled beat is held unchanged
   initial begin
      beat_t exp, held;
      logic  stall = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall = 1'b0;
         end else begin
            if (in_ready && out_valid) viol++;
            if (stall)
               chk("stall_hold", {out_valid, out_data, out_index, out_last},
                   {1'b1, held.data, held.index, held.last});
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_beat: got data %0h idx %0d, expected no beat",
                           out_data, out_index);
               end else begin
                  exp = q.pop_front();
                  chk("beat", {out_data, out_index, out_last}, exp);
               end
            end
            stall = out_valid && !out_ready;
            held  = '{out_data, out_index, out_last};
         end
      end
   end

   // issue one frame; returns 1 ns after the capture edge
   task automatic send(input logic [7:0] s [9], input logic [3:0] cnt, input bit keep);
      int n;
      bit ok = 0;
      n = (cnt > 9) ? 9 : int'(cnt);
      for (int i = 0; i < n; i++) q.push_back('{s[i], 4'(i + 1), (i == n - 1)});
      {in1, in2, in3, in4, in5, in6, in7, in8, in9} =
         {s[0], s[1], s[2], s[3], s[4], s[5], s[6], s[7], s[8]};
      unique_count = cnt;
      in_valid = 1'b1;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            ok = 1;
         end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL capture_timeout: got in_ready low for 100 cycles, expected capture");
      end
      last_cap = cyc;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain();
      bool_loop: for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (q.size() == 0 && !out_valid) return;
      end
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", q.size());
   endtask

   initial begin
      logic [7:0] s [9];
      int first_cap;

      // reset held two cycles
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_outs", {out_valid, out_last, out_data, out_index}, 0);
      chk("post_rst_counters", {frames_done, empty_frames}, 0);

      // single frame 5,3,9
      @(posedge clk); #1;
      s = '{8'd5, 8'd3, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      send(s, 4'd3, 0);
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("single_last_on_3rd", {out_last, out_data}, {1'b1, 8'd9});
      chk("single_busy", in_ready, 0);
      @(negedge clk);
      chk("single_ready_back", in_ready, 1);
      chk("single_frames_done", frames_done, 1);
      chk("single_idle_valid", out_valid, 0);

      // backpressure, 9 slots 1..9
      @(posedge clk); #1;
      ready_mode = 1;
      s = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      send(s, 4'd9, 0);
      drain();
      @(posedge clk); #1; ready_mode = 0;
      chk("bp_frames_done", frames_done, 2);

      // empty frame
      s = '{8'h77, 8'h66, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      send(s, 4'd0, 0);
      @(negedge clk);
      chk("empty_no_valid", out_valid, 0);
      chk("empty_ready", in_ready, 1);
      chk("empty_count", empty_frames, 1);

      // clamp 15 -> 9
      @(posedge clk); #1;
      s = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
      send(s, 4'd15, 0);
      drain();
      chk("clamp_frames_done", frames_done, 3);

      // reset after beat 2 of a 6-beat frame
      @(posedge clk); #1;
      s = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29};
      send(s, 4'd6, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      q.delete();
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_frames_done", frames_done, 0);
      @(posedge clk); #1;
      s = '{8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send(s, 4'd1, 0);
      drain();
      chk("aa_frames_done", frames_done, 1);

      // back-to-back 256 single-beat frames, fresh counters
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      first_cap = 0;
      for (int f = 0; f < 256; f++) begin
         s = '{8'(f), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
         send(s, 4'd1, 1);
         if (f == 0) first_cap = last_cap;
      end
      in_valid = 1'b0;
      drain();
      chk("b2b_spacing", last_cap - first_cap, 510);
      chk("b2b_frames_wrap", frames_done, 0);
      chk("b2b_empty", empty_frames, 0);
      chk("ready_in_send", viol, 0);
      chk("queue_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
